// File: rtl/code_stream_packer.sv
// Packs one block of variable-length codes into a dense MSB-first 32-bit word stream.
// Optional macro PACKER_STATS_EN adds the o_block_bits unpadded-bit counter.
module code_stream_packer #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TOTAL_BITS  = 34,
    parameter int unsigned TOTAL_WORDS = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [2:0]            i_code,
    input  logic [TOTAL_BITS-1:0] i_comp_word,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
`ifdef PACKER_STATS_EN
    ,
    output logic [$clog2(TOTAL_WORDS*TOTAL_BITS+1)-1:0] o_block_bits
`endif
);

    localparam int unsigned BUF_W  = DATA_WIDTH + TOTAL_BITS;
    localparam int unsigned FILL_W = $clog2(BUF_W);
    localparam int unsigned CNT_W  = $clog2(TOTAL_WORDS + 1);

    typedef enum logic [1:0] {StIdle, StAccept, StFlush, StDone} state_e;

    state_e                r_state, w_state_nxt;
    logic [BUF_W-1:0]      r_buf, w_buf_nxt;
    logic [FILL_W-1:0]     r_fill, w_fill_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [DATA_WIDTH-1:0] r_out_data, w_out_data_nxt;
    logic                  r_out_last, w_out_last_nxt;
    logic                  r_last_loaded, w_last_loaded_nxt;
    logic                  r_err, w_err_nxt;

    logic [FILL_W-1:0]     w_len;
    logic                  w_code_bad;
    logic [TOTAL_BITS-1:0] w_mask;
    logic [BUF_W-1:0]      w_ins;
    logic [BUF_W-1:0]      w_mbuf;
    logic [FILL_W-1:0]     w_mfill;
    logic [FILL_W-1:0]     w_left;
    logic                  w_acc;
    logic                  w_final;
    logic                  w_can_load;
    logic                  w_load;
    logic                  w_load_last;

    always_comb begin
        w_len      = '0;
        w_code_bad = 1'b0;
        unique case (i_code)
            3'b000:  w_len = FILL_W'(2);
            3'b001:  w_len = FILL_W'(6);
            3'b010:  w_len = FILL_W'(12);
            3'b011:  w_len = FILL_W'(16);
            3'b100:  w_len = FILL_W'(24);
            3'b101:  w_len = FILL_W'(34);
            default: w_code_bad = 1'b1;
        endcase
    end

    // Left-justify the masked code, then drop it just below the buffered bits.
    assign w_mask = {TOTAL_BITS{1'b1}} >> (FILL_W'(TOTAL_BITS) - w_len);
    assign w_ins  = ({i_comp_word & w_mask, {DATA_WIDTH{1'b0}}} << (FILL_W'(TOTAL_BITS) - w_len))
                    >> r_fill;

    assign o_ready    = (r_state == StAccept) && (r_fill < FILL_W'(DATA_WIDTH));
    assign w_acc      = i_valid && o_ready;
    assign w_final    = w_acc && (r_cnt == CNT_W'(TOTAL_WORDS - 1));
    assign w_mbuf     = r_buf | (w_acc ? w_ins : '0);
    assign w_mfill    = r_fill + (w_acc ? w_len : '0);
    assign w_left     = (w_mfill >= FILL_W'(DATA_WIDTH)) ? w_mfill - FILL_W'(DATA_WIDTH) : '0;
    assign w_can_load = !r_out_valid || i_ready;

    always_comb begin
        w_load      = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            StAccept: begin
                w_load      = w_can_load && (w_mfill >= FILL_W'(DATA_WIDTH));
                w_load_last = w_final && (w_mfill == FILL_W'(DATA_WIDTH));
            end
            StFlush: begin
                // Any residual (full or partial) is emitted until the last word is in flight.
                w_load      = w_can_load && !r_last_loaded;
                w_load_last = (w_mfill <= FILL_W'(DATA_WIDTH));
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle:   if (i_start) w_state_nxt = StAccept;
            StAccept: if (w_final) w_state_nxt = StFlush;
            StFlush:  if (r_out_valid && r_out_last && i_ready) w_state_nxt = StDone;
            StDone:   w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        w_buf_nxt         = w_mbuf;
        w_fill_nxt        = w_mfill;
        w_cnt_nxt         = r_cnt + CNT_W'(w_acc);
        w_out_valid_nxt   = r_out_valid;
        w_out_data_nxt    = r_out_data;
        w_out_last_nxt    = r_out_last;
        w_last_loaded_nxt = r_last_loaded;
        w_err_nxt         = r_err | (w_acc && w_code_bad);
        if (r_out_valid && i_ready) begin
            w_out_valid_nxt = 1'b0;
        end
        if (w_load) begin
            w_out_valid_nxt   = 1'b1;
            w_out_data_nxt    = w_mbuf[BUF_W-1 -: DATA_WIDTH];
            w_out_last_nxt    = w_load_last;
            w_buf_nxt         = w_mbuf << DATA_WIDTH;
            w_fill_nxt        = w_left;
            w_last_loaded_nxt = r_last_loaded | w_load_last;
        end
        if (r_state == StIdle && i_start) begin
            w_buf_nxt         = '0;
            w_fill_nxt        = '0;
            w_cnt_nxt         = '0;
            w_err_nxt         = 1'b0;
            w_last_loaded_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_buf         <= '0;
            r_fill        <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_last    <= 1'b0;
            r_last_loaded <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_buf         <= w_buf_nxt;
            r_fill        <= w_fill_nxt;
            r_cnt         <= w_cnt_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_last    <= w_out_last_nxt;
            r_last_loaded <= w_last_loaded_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_last  = r_out_last;
    assign o_err   = r_err;
    assign o_busy  = (r_state == StAccept) || (r_state == StFlush);
    assign o_done  = (r_state == StDone);

`ifdef PACKER_STATS_EN
    logic [$clog2(TOTAL_WORDS*TOTAL_BITS+1)-1:0] r_block_bits;

    // Only accepted codes add bits, so the count freezes naturally after the block.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_block_bits <= '0;
        end else if (r_state == StIdle && i_start) begin
            r_block_bits <= '0;
        end else if (w_acc) begin
            r_block_bits <= r_block_bits + $bits(r_block_bits)'(w_len);
        end
    end

    assign o_block_bits = r_block_bits;
`endif

endmodule

// File: tb/tb_code_stream_packer.sv
// Randomised and directed bench for code_stream_packer against a bit-queue reference model.
module tb_code_stream_packer;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_valid, o_ready, i_ready;
    logic [2:0]  i_code;
    logic [33:0] i_comp_word;
    logic        o_valid, o_last, o_busy, o_done, o_err;
    logic [31:0] o_data;
`ifdef PACKER_STATS_EN
    logic [9:0]  o_block_bits;
`endif

    always #5 clk = ~clk;

    code_stream_packer dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_valid(i_valid), .o_ready(o_ready),
        .i_code(i_code), .i_comp_word(i_comp_word), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
`ifdef PACKER_STATS_EN
        , .o_block_bits(o_block_bits)
`endif
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [2:0]  blk_code [16];
    logic [33:0] blk_word [16];
    logic [31:0] exp_words [$];
    int          exp_bits;
    logic        exp_err;
    bit          drv_done;
    bit          saw_not_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int code_len(input logic [2:0] c);
        case (c)
            3'd0: return 2;
            3'd1: return 6;
            3'd2: return 12;
            3'd3: return 16;
            3'd4: return 24;
            3'd5: return 34;
            default: return 0;
        endcase
    endfunction

    // Reference: serialise every code MSB-first into one bit queue, then slice into words.
    task automatic build_model();
        bit bq [$];
        exp_words.delete();
        exp_bits = 0;
        exp_err  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            int l = code_len(blk_code[i]);
            if (blk_code[i] > 3'd5) exp_err = 1'b1;
            for (int b = l - 1; b >= 0; b--) bq.push_back(blk_word[i][b]);
            exp_bits += l;
        end
        while (bq.size() > 0) begin
            logic [31:0] w = '0;
            for (int j = 0; j < 32; j++) begin
                bit bt = 1'b0;
                if (bq.size() > 0) bt = bq.pop_front();
                w = {w[30:0], bt};
            end
            exp_words.push_back(w);
        end
        if (exp_words.size() == 0) exp_words.push_back(32'h0);
    endtask

    task automatic set_code(input int i, input logic [2:0] c, input logic [63:0] raw);
        int l = code_len(c);
        blk_code[i] = c;
        blk_word[i] = 34'(raw & ((64'd1 << l) - 64'd1));
    endtask

    task automatic rand_block(input bit allow_bad);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] c = 3'($urandom_range(0, allow_bad ? 7 : 5));
            if (i == 0) c = 3'($urandom_range(0, 5));
            set_code(i, c, {$urandom, $urandom});
        end
    endtask

    task automatic start_block();
        @(posedge clk); #1 i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
    endtask

    task automatic drive_codes(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            int  guard = 0;
            bit  acc = 1'b0;
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            i_valid     = 1'b1;
            i_code      = blk_code[i];
            i_comp_word = blk_word[i];
            do begin
                @(negedge clk);
                acc = o_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 500);
            check("code_accepted", 64'(acc), 64'd1);
        end
        i_valid  = 1'b0;
        drv_done = 1'b1;
    endtask

    task automatic consume(input bit stall);
        int          k = 0;
        int          cyc = 0;
        bit          got_last = 1'b0;
        bit          hold = 1'b0;
        logic [31:0] hold_data = '0;
        logic        hold_last = 1'b0;
        while (!got_last && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_data", 64'(o_data), 64'(hold_data));
                check("hold_last", 64'(o_last), 64'(hold_last));
            end
            if (stall && cyc >= 10 && cyc < 30) begin
                i_ready = 1'b0;
                if (!drv_done && !o_ready) saw_not_ready = 1'b1;
            end else begin
                i_ready = ($urandom_range(0, 3) != 0);
            end
            hold      = o_valid && !i_ready;
            hold_data = o_data;
            hold_last = o_last;
            if (o_valid && i_ready) begin
                if (k < exp_words.size()) begin
                    check("word_data", 64'(o_data), 64'(exp_words[k]));
                    check("word_last", 64'(o_last), 64'(k == exp_words.size() - 1));
                end else begin
                    check("extra_word", 64'(k), 64'(exp_words.size() - 1));
                end
                if (o_last) got_last = 1'b1;
                k++;
            end
        end
        check("word_count", 64'(k), 64'(exp_words.size()));
    endtask

    task automatic run_block(input bit stall, input bit gaps);
        build_model();
        drv_done      = 1'b0;
        saw_not_ready = 1'b0;
        start_block();
        check("busy_after_start", 64'(o_busy), 64'd1);
        check("err_cleared", 64'(o_err), 64'd0);
        fork
            drive_codes(16, gaps);
            consume(stall);
        join
        @(negedge clk);
        check("done_pulse", 64'(o_done), 64'd1);
        check("err_flag", 64'(o_err), 64'(exp_err));
`ifdef PACKER_STATS_EN
        check("block_bits", 64'(o_block_bits), 64'(exp_bits));
`endif
        i_ready = 1'b0;
        @(negedge clk);
        check("done_single", 64'(o_done), 64'd0);
        check("idle_not_busy", 64'(o_busy), 64'd0);
        check("err_sticky", 64'(o_err), 64'(exp_err));
        if (stall) check("ready_dropped", 64'(saw_not_ready), 64'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_code = '0; i_comp_word = '0;
        repeat (2) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 64'({o_ready, o_valid, o_data, o_last, o_busy, o_done, o_err}),
              64'd0);
        i_valid = 1'b1;
        @(negedge clk);
        check("idle_no_ready", 64'(o_ready), 64'd0);
        i_valid = 1'b0;

        // Test 1: sixteen 2-bit codes make exactly one word.
        for (int i = 0; i < 16; i++) set_code(i, 3'd0, 64'd0);
        run_block(1'b0, 1'b0);

        // Tests 2 and 4: sixteen 34-bit codes, free-running then with an output stall.
        for (int i = 0; i < 16; i++) set_code(i, 3'd5, 64'h1_DEAD_BEEF);
        run_block(1'b0, 1'b0);
        run_block(1'b1, 1'b0);

        // Test 3: one 6-bit code then fifteen 2-bit codes (36 bits, padded tail).
        set_code(0, 3'd1, 64'h25);
        for (int i = 1; i < 16; i++) set_code(i, 3'd0, 64'd0);
        run_block(1'b0, 1'b0);

        // Test 5: an invalid code inside an otherwise valid block.
        for (int i = 0; i < 16; i++) set_code(i, 3'd3, {$urandom, $urandom});
        set_code(7, 3'd7, 64'hFFFF);
        run_block(1'b0, 1'b1);

        // Test 6: reset after seven codes, then a clean block.
        for (int i = 0; i < 16; i++) set_code(i, 3'($urandom_range(0, 3)), {$urandom, $urandom});
        start_block();
        i_ready  = 1'b1;
        drv_done = 1'b0;
        drive_codes(7, 1'b0);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs",
              64'({o_ready, o_valid, o_data, o_last, o_busy, o_done, o_err}), 64'd0);
`ifdef PACKER_STATS_EN
        check("mid_reset_bits", 64'(o_block_bits), 64'd0);
`endif
        i_ready = 1'b0;
        run_block(1'b0, 1'b1);

        // Randomised blocks, some with invalid codes and stalls.
        for (int r = 0; r < 8; r++) begin
            rand_block(r[0]);
            run_block(r == 5, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
